// File: rtl/vospi_pkg.sv
// ============================================================================
// Module  : vospi_pkg
// Brief   : Shared constants and state type for the VoSPI slave transmitter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package vospi_pkg;

  localparam logic [15:0] DISCARD_ID = 16'h0F00;
  localparam int          HDR_BYTES  = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ID_HI   = 3'd1,
    ID_LO   = 3'd2,
    CRC_HI  = 3'd3,
    CRC_LO  = 3'd4,
    PAYLOAD = 3'd5
  } vospi_tx_state_e;

endpackage

`default_nettype wire

// File: rtl/vospi_sclk_sync.sv
// ============================================================================
// Module  : vospi_sclk_sync
// Brief   : Brings sclk/cs into the clk_i domain and flags sclk falling edges.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module vospi_sclk_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sclk_i,
  input  logic cs_i,
  output logic cs_n_s,
  output logic sclk_fall
);

  logic r_sclk_meta;
  logic r_sclk_sync;
  logic r_sclk_prev;
  logic r_cs_meta;
  logic r_cs_sync;

  // Both lines idle high, so reset to 1 to avoid a spurious edge on release.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_sclk_meta <= 1'b1;
      r_sclk_sync <= 1'b1;
      r_sclk_prev <= 1'b1;
      r_cs_meta   <= 1'b1;
      r_cs_sync   <= 1'b1;
    end else begin
      r_sclk_meta <= sclk_i;
      r_sclk_sync <= r_sclk_meta;
      r_sclk_prev <= r_sclk_sync;
      r_cs_meta   <= cs_i;
      r_cs_sync   <= r_cs_meta;
    end
  end

  assign cs_n_s    = r_cs_sync;
  assign sclk_fall = r_sclk_prev & ~r_sclk_sync;

endmodule

`default_nettype wire

// File: rtl/vospi_slave_tx.sv
// ============================================================================
// Module  : vospi_slave_tx
// Brief   : VoSPI sensor-side SPI slave (mode 3) sending discard/video packets.
//           Optional statistics counters enabled by VOSPI_SLAVE_STATS_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module vospi_slave_tx
  import vospi_pkg::*;
#(
  parameter int packet_bytes_p  = 164,
  parameter int frame_packets_p = 60
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       sclk_i,
  input  logic       cs_i,
  output logic       miso_o,
  input  logic       frame_valid_i,
  input  logic [7:0] pay_data_i,
  input  logic       pay_valid_i,
  output logic       pay_ready_o,
  output logic       frame_done_o,
  output logic       underrun_o,
  output logic       busy_o
`ifdef VOSPI_SLAVE_STATS_EN
  ,
  output logic [15:0] discard_cnt_o,
  output logic [15:0] underrun_cnt_o
`endif
);

  localparam int PAY_BYTES = packet_bytes_p - HDR_BYTES;
  localparam int BC_W      = (PAY_BYTES > 1) ? $clog2(PAY_BYTES) : 1;

  logic w_cs_n_s;
  logic w_sclk_fall;
  logic r_cs_prev;
  logic w_cs_fall;

  vospi_tx_state_e r_state, w_state_nx;
  logic [7:0]      r_sr, w_sr_nx;
  logic [2:0]      r_bit, w_bit_nx;
  logic [BC_W-1:0] r_byte_cnt, w_byte_cnt_nx;
  logic [11:0]     r_pkt_num, w_pkt_num_nx;
  logic [15:0]     r_id, w_id_nx;
  logic            r_is_frame, w_is_frame_nx;
  logic            r_miso, w_miso_nx;
  logic            r_pay_ready, w_pay_ready_nx;
  logic            r_underrun, w_underrun_nx;
  logic            r_frame_done, w_frame_done_nx;
  logic            w_eop, w_load_pay, w_start;

  logic [11:0] w_pkt_after;
  logic [11:0] w_start_num;
  logic        w_start_frame;
  logic [15:0] w_start_id;

  vospi_sclk_sync u_sync (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .sclk_i    (sclk_i),
    .cs_i      (cs_i),
    .cs_n_s    (w_cs_n_s),
    .sclk_fall (w_sclk_fall)
  );

  assign w_cs_fall = r_cs_prev & ~w_cs_n_s;

  // Packet number the next packet will carry: current one from IDLE, advanced one at end of packet.
  assign w_pkt_after   = !r_is_frame ? r_pkt_num :
                         (r_pkt_num == 12'(frame_packets_p - 1)) ? 12'd0 : r_pkt_num + 12'd1;
  assign w_start_num   = (r_state == IDLE) ? r_pkt_num : w_pkt_after;
  assign w_start_frame = frame_valid_i || (w_start_num != 12'd0);
  assign w_start_id    = w_start_frame ? {4'h0, w_start_num} : DISCARD_ID;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= IDLE;
      r_sr         <= 8'h00;
      r_bit        <= 3'd0;
      r_byte_cnt   <= '0;
      r_pkt_num    <= 12'd0;
      r_id         <= 16'h0000;
      r_is_frame   <= 1'b0;
      r_miso       <= 1'b0;
      r_pay_ready  <= 1'b0;
      r_underrun   <= 1'b0;
      r_frame_done <= 1'b0;
      r_cs_prev    <= 1'b1;
    end else begin
      r_state      <= w_state_nx;
      r_sr         <= w_sr_nx;
      r_bit        <= w_bit_nx;
      r_byte_cnt   <= w_byte_cnt_nx;
      r_pkt_num    <= w_pkt_num_nx;
      r_id         <= w_id_nx;
      r_is_frame   <= w_is_frame_nx;
      r_miso       <= w_miso_nx;
      r_pay_ready  <= w_pay_ready_nx;
      r_underrun   <= w_underrun_nx;
      r_frame_done <= w_frame_done_nx;
      r_cs_prev    <= w_cs_n_s;
    end
  end

  always_comb begin
    w_state_nx      = r_state;
    w_sr_nx         = r_sr;
    w_bit_nx        = r_bit;
    w_byte_cnt_nx   = r_byte_cnt;
    w_pkt_num_nx    = r_pkt_num;
    w_id_nx         = r_id;
    w_is_frame_nx   = r_is_frame;
    w_miso_nx       = r_miso;
    w_pay_ready_nx  = 1'b0;
    w_underrun_nx   = 1'b0;
    w_frame_done_nx = 1'b0;
    w_eop           = 1'b0;
    w_load_pay      = 1'b0;
    w_start         = 1'b0;

    if (r_state == IDLE) begin
      w_miso_nx = 1'b0;
      w_start   = w_cs_fall;
    end else if (w_cs_n_s) begin
      w_state_nx = IDLE;
      w_miso_nx  = 1'b0;
    end else if (w_sclk_fall) begin
      w_miso_nx = r_sr[7];
      w_sr_nx   = {r_sr[6:0], 1'b0};
      w_bit_nx  = r_bit + 3'd1;
      if (r_bit == 3'd7) begin
        // The next byte is loaded on the fall that drives the last bit of the current one.
        case (r_state)
          ID_HI:   begin w_state_nx = ID_LO;  w_sr_nx = r_id[7:0];  end
          ID_LO:   begin w_state_nx = CRC_HI; w_sr_nx = r_id[15:8]; end
          CRC_HI:  begin w_state_nx = CRC_LO; w_sr_nx = r_id[7:0];  end
          CRC_LO:  begin
            w_state_nx    = PAYLOAD;
            w_byte_cnt_nx = '0;
            w_load_pay    = 1'b1;
          end
          PAYLOAD: begin
            if (r_byte_cnt == BC_W'(PAY_BYTES - 1)) begin
              w_eop           = 1'b1;
              w_pkt_num_nx    = w_pkt_after;
              w_frame_done_nx = r_is_frame && (r_pkt_num == 12'(frame_packets_p - 1));
              w_start         = 1'b1;
            end else begin
              w_byte_cnt_nx = r_byte_cnt + 1'b1;
              w_load_pay    = 1'b1;
            end
          end
          default: w_state_nx = IDLE;
        endcase
      end
    end

    if (w_load_pay) begin
      w_sr_nx        = (r_is_frame && pay_valid_i) ? pay_data_i : 8'h00;
      w_pay_ready_nx = r_is_frame && pay_valid_i;
      w_underrun_nx  = r_is_frame && !pay_valid_i;
    end

    if (w_start) begin
      w_state_nx    = ID_HI;
      w_sr_nx       = w_start_id[15:8];
      w_bit_nx      = 3'd0;
      w_byte_cnt_nx = '0;
      w_id_nx       = w_start_id;
      w_is_frame_nx = w_start_frame;
    end
  end

  assign miso_o       = r_miso;
  assign pay_ready_o  = r_pay_ready;
  assign underrun_o   = r_underrun;
  assign frame_done_o = r_frame_done;
  assign busy_o       = (r_state != IDLE);

`ifdef VOSPI_SLAVE_STATS_EN
  logic [15:0] r_discard_cnt;
  logic [15:0] r_underrun_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_discard_cnt  <= 16'h0000;
      r_underrun_cnt <= 16'h0000;
    end else begin
      if (w_eop && !r_is_frame && (r_discard_cnt != 16'hFFFF))
        r_discard_cnt <= r_discard_cnt + 16'd1;
      if (w_underrun_nx && (r_underrun_cnt != 16'hFFFF))
        r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  assign discard_cnt_o  = r_discard_cnt;
  assign underrun_cnt_o = r_underrun_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vospi_slave_tx.sv
// ============================================================================
// Module  : tb_vospi_slave_tx
// Brief   : Mode-3 SPI master driving vospi_slave_tx against a packet-level model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vospi_slave_tx;

  localparam int PKT_BYTES  = 24;
  localparam int FRAME_PKTS = 12;
  localparam int PAY        = PKT_BYTES - 4;
  localparam int HALF       = 40;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       sclk_i;
  logic       cs_i;
  logic       miso_o;
  logic       frame_valid_i;
  logic [7:0] pay_data_i;
  logic       pay_valid_i;
  logic       pay_ready_o;
  logic       frame_done_o;
  logic       underrun_o;
  logic       busy_o;
`ifdef VOSPI_SLAVE_STATS_EN
  logic [15:0] discard_cnt_o;
  logic [15:0] underrun_cnt_o;
`endif

  vospi_slave_tx #(
    .packet_bytes_p  (PKT_BYTES),
    .frame_packets_p (FRAME_PKTS)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .sclk_i        (sclk_i),
    .cs_i          (cs_i),
    .miso_o        (miso_o),
    .frame_valid_i (frame_valid_i),
    .pay_data_i    (pay_data_i),
    .pay_valid_i   (pay_valid_i),
    .pay_ready_o   (pay_ready_o),
    .frame_done_o  (frame_done_o),
    .underrun_o    (underrun_o),
    .busy_o        (busy_o)
`ifdef VOSPI_SLAVE_STATS_EN
    ,
    .discard_cnt_o  (discard_cnt_o),
    .underrun_cnt_o (underrun_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Payload source: random byte stream, advanced by each pay_ready_o pulse.
  logic [7:0] src_mem [0:1023];
  logic [9:0] src_idx = 10'd0;
  assign pay_data_i = src_mem[src_idx];
  always @(negedge clk_i) if (pay_ready_o) src_idx = src_idx + 10'd1;

  int fd_cnt  = 0;
  int ur_cnt  = 0;
  int rdy_cnt = 0;
  always @(posedge clk_i) begin
    if (frame_done_o) fd_cnt  <= fd_cnt + 1;
    if (underrun_o)   ur_cnt  <= ur_cnt + 1;
    if (pay_ready_o)  rdy_cnt <= rdy_cnt + 1;
  end

  int n_assert = 0;
  int n_fail   = 0;
  int m_pkt    = 0;
  int m_idx    = 0;
  logic [7:0] rx [0:PKT_BYTES-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Clocks nbytes bytes out of the slave; optionally withdraws pay_valid_i around one fall.
  task automatic spi_packet(input int nbytes, input bit hold, input int drop_fall);
    logic [7:0] b;
    b = 8'h00;
    cs_i = 1'b0;
    #(HALF);
    for (int i = 0; i < nbytes; i++) begin
      for (int k = 0; k < 8; k++) begin
        if (i * 8 + k + 1 == drop_fall) pay_valid_i = 1'b0;
        sclk_i = 1'b0;
        #(HALF);
        sclk_i = 1'b1;
        b = {b[6:0], miso_o};
        #(HALF);
        pay_valid_i = 1'b1;
      end
      rx[i] = b;
    end
    if (!hold) begin
      cs_i = 1'b1;
      #(4 * HALF);
    end
  endtask

  // Packet-level model: predicts ID, CRC copy and payload, then tracks frame position and source use.
  task automatic do_packet(input string tag, input bit hold, input int nbytes, input int drop_pay);
    bit          frm;
    logic [15:0] id;
    logic [7:0]  e_pay [0:PAY-1];
    int          k, bad, first_bad;
    frm = frame_valid_i || (m_pkt != 0);
    id  = frm ? 16'(m_pkt) : 16'h0F00;
    k   = m_idx;
    for (int p = 0; p < PAY; p++) begin
      if (!frm || p == drop_pay) e_pay[p] = 8'h00;
      else begin
        e_pay[p] = src_mem[k[9:0]];
        k++;
      end
    end
    spi_packet(nbytes, hold, (drop_pay >= 0) ? (4 + drop_pay) * 8 : -1);
    check({tag, " id"},  {16'h0, rx[0], rx[1]}, {16'h0, id});
    check({tag, " crc"}, {16'h0, rx[2], rx[3]}, {16'h0, id});
    bad = 0;
    first_bad = -1;
    for (int p = 0; p < nbytes - 4; p++) begin
      if (rx[4 + p] !== e_pay[p]) begin
        bad++;
        if (first_bad < 0) first_bad = p;
      end
    end
    check($sformatf("%s payload errors (first at %0d)", tag, first_bad), bad, 0);
    if (nbytes == PKT_BYTES) begin
      if (frm) begin
        m_idx = k;
        m_pkt = (m_pkt + 1) % FRAME_PKTS;
      end
    end else if (frm && nbytes > 4) begin
      m_idx += nbytes - 3;
    end
    check({tag, " source consumed"}, {22'h0, src_idx}, m_idx);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) src_mem[i] = 8'($urandom);
    reset_i = 1'b1;
    cs_i = 1'b1;
    sclk_i = 1'b1;
    frame_valid_i = 1'b0;
    pay_valid_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("reset miso", miso_o, 0);
    check("reset busy", busy_o, 0);
    check("reset pay_ready", pay_ready_o, 0);
    check("reset frame_done", frame_done_o, 0);
    check("reset underrun", underrun_o, 0);
    reset_i = 1'b0;
    repeat (4) @(negedge clk_i);

    // Discard packet with no frame ready
    do_packet("t1 discard", 1'b0, PKT_BYTES, -1);
    check("t1 pay_ready pulses", rdy_cnt, 0);

    // Full frame, cs held low across packets
    frame_valid_i = 1'b1;
    repeat ($urandom_range(2, 10)) @(negedge clk_i);
    for (int i = 0; i < FRAME_PKTS; i++) begin
      do_packet($sformatf("t2 pkt%0d", i), (i != FRAME_PKTS - 1), PKT_BYTES, -1);
      if (i == FRAME_PKTS - 2) check("t2 frame_done before last", fd_cnt, 0);
    end
    check("t2 frame_done count", fd_cnt, 1);

    // Discard between frames, then a new frame
    frame_valid_i = 1'b0;
    do_packet("t3 discard", 1'b0, PKT_BYTES, -1);
    frame_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(2, 10)) @(negedge clk_i);
      do_packet($sformatf("t3 pkt%0d", i), 1'b0, PKT_BYTES, -1);
    end

    // Underrun on payload byte 10 of packet 5
    do_packet("t4 pkt5 underrun", 1'b0, PKT_BYTES, 10);
    check("t4 underrun count", ur_cnt, 1);
    do_packet("t4 pkt6", 1'b0, PKT_BYTES, -1);

    // Abort packet 7 part way, then resend
    do_packet("t5 pkt7 aborted", 1'b0, 14, -1);
    check("t5 miso while cs high", miso_o, 0);
    check("t5 busy while cs high", busy_o, 0);
    repeat ($urandom_range(2, 10)) @(negedge clk_i);
    do_packet("t5 pkt7 resend", 1'b0, PKT_BYTES, -1);
    check("t5 frame_done count", fd_cnt, 1);

    // Reset in the middle of the payload of packet 8
    do_packet("t6 pkt8 partial", 1'b1, 18, -1);
    check("t6 busy mid packet", busy_o, 1);
`ifdef VOSPI_SLAVE_STATS_EN
    check("stats discard count", discard_cnt_o, 2);
    check("stats underrun count", underrun_cnt_o, 1);
`endif
    reset_i = 1'b1;
    #1;
    check("t6 reset miso", miso_o, 0);
    check("t6 reset busy", busy_o, 0);
    check("t6 reset pay_ready", pay_ready_o, 0);
    check("t6 reset frame_done", frame_done_o, 0);
    check("t6 reset underrun", underrun_o, 0);
`ifdef VOSPI_SLAVE_STATS_EN
    check("stats discard after reset", discard_cnt_o, 0);
    check("stats underrun after reset", underrun_cnt_o, 0);
`endif
    #9;
    cs_i = 1'b1;
    #(HALF);
    reset_i = 1'b0;
    #(HALF);
    m_pkt = 0;
    do_packet("t6 after reset pkt0", 1'b0, PKT_BYTES, -1);
    check("t6 underrun total", ur_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
